// File: rtl/result_collector.sv
// -----------------------------------------------------------------------------
// result_collector
//
// Return path of the TLM calculator bench. Results presented by the bfm with
// `done` are captured into a small FIFO. They are then streamed back to the
// host as a valid/ready stream. The last word of every NUM-result batch is
// marked with res_tlast, and rcv_en toggles once for each completed batch.
//
// Optional feature (compile-time macro):
//   COLLECTOR_EDGE_EN  defined   : a push is a rising edge of `done`.
//                      undefined : a push is every cycle with `done` high.
//
// The occupancy counter is the architectural level. A three-state collector
// FSM (IDLE / STREAM / FULL) mirrors it and provides the empty/full decode. As
// a result, res_tvalid and the overflow decision come straight from a state
// register.
// -----------------------------------------------------------------------------
module result_collector #(
  parameter int NUM       = 100,  // results per batch, 1..65535
  parameter int RES_WIDTH = 16,   // result word width
  parameter int DEPTH     = 8     // FIFO depth, power of two, >= 2
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       done,
  input  logic [RES_WIDTH-1:0]       res_i,
  output logic                       res_tvalid,
  input  logic                       res_tready,
  output logic [RES_WIDTH-1:0]       res_tdata,
  output logic                       res_tlast,
  output logic                       rcv_en,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       ovf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [LW-1:0] LVL_FULL     = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ONE_LESS = LW'(DEPTH - 1);
  localparam logic [LW-1:0] LVL_ONE      = LW'(1);
  localparam logic [15:0]   BIDX_LAST    = 16'(NUM - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,   // occupancy 0
    ST_STREAM = 2'd1,   // 0 < occupancy < DEPTH
    ST_FULL   = 2'd2    // occupancy == DEPTH
  } state_t;

  // ---------------------------------------------------------------------------
  // Storage and state
  // ---------------------------------------------------------------------------
  logic [RES_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [LW-1:0]        count;
  logic [15:0]          bidx;
  state_t               state;
  state_t               state_nxt;

  logic                 push_req;
  logic                 pop;
  logic                 wr_en;
  logic                 is_full;
  logic                 last_pop;

  // ---------------------------------------------------------------------------
  // Push detection
  // ---------------------------------------------------------------------------
`ifdef COLLECTOR_EDGE_EN
  logic done_q;

  // Remember the previous value of done so that only its rising edge pushes.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done;
    end
  end

  assign push_req = done & ~done_q;
`else
  // Level mode: the bfm strobes done for exactly one cycle per result.
  assign push_req = done;
`endif

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  // A pop at the same edge frees a slot. For that reason, a push into a full
  // FIFO is still accepted when the host takes a word in the same cycle.
  assign pop      = res_tvalid & res_tready;
  assign wr_en    = push_req & (~is_full | pop);
  assign last_pop = pop & res_tlast;

  // ---------------------------------------------------------------------------
  // Collector FSM: state register
  // ---------------------------------------------------------------------------
  // Hold the collector state; reset lands in IDLE (empty).
  // NOTE: sequential state uses non-blocking (<=) assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Collector FSM: next-state logic
  // ---------------------------------------------------------------------------
  // Track occupancy class from the accepted push/pop pair and the current level.
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        // An empty FIFO has nothing to pop; any accepted push makes it non-empty.
        if (wr_en) begin
          state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (wr_en && !pop && count == LVL_ONE_LESS) begin
          state_nxt = ST_FULL;
        end else if (pop && !wr_en && count == LVL_ONE) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_FULL: begin
        // A pop with a concurrent push leaves occupancy at DEPTH, so the FSM
        // stays FULL. A pop on its own drops the FIFO back to streaming.
        if (pop && !wr_en) begin
          state_nxt = ST_STREAM;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Collector FSM: output decode
  // ---------------------------------------------------------------------------
  // Stream outputs depend only on registered state: no path from res_tready or done.
  always_comb begin
    res_tvalid = (state != ST_IDLE);
    is_full    = (state == ST_FULL);
    res_tlast  = res_tvalid && (bidx == BIDX_LAST);
    // Gating the data with valid makes an empty FIFO read as zero. This holds
    // after reset even though the storage itself is not cleared.
    res_tdata  = res_tvalid ? mem[rd_ptr] : '0;
  end

  // ---------------------------------------------------------------------------
  // FIFO storage
  // ---------------------------------------------------------------------------
  // Write the captured result at the write pointer.
  // NOTE: the storage array has no reset. Entries are only visible through
  // rd_ptr while occupancy is non-zero, so clearing the pointers and count is
  // enough to discard them.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_ptr] <= res_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers and occupancy
  // ---------------------------------------------------------------------------
  // Advance the pointers (wrapping at DEPTH) and keep the occupancy count.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({wr_en, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  assign level_o = count;

  // ---------------------------------------------------------------------------
  // Overflow flag
  // ---------------------------------------------------------------------------
  // Sticky: set when a push finds the FIFO full and no pop frees a slot.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ovf_o <= 1'b0;
    end else if (push_req && is_full && !pop) begin
      ovf_o <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Batch tracking
  // ---------------------------------------------------------------------------
  // Count popped words within the batch; wrap and toggle rcv_en on the last.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bidx   <= '0;
      rcv_en <= 1'b0;
    end else if (last_pop) begin
      bidx   <= '0;
      rcv_en <= ~rcv_en;
    end else if (pop) begin
      bidx   <= bidx + 16'd1;
    end
  end

endmodule
